// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: operation sequencer and AH:AL accumulator for the 4-bit ALU.
// Runs single-pass ADD/SUB/AND, shift-add MUL and restoring DIV behind a
// start/busy/done handshake. The ALU itself is external: this block drives
// its operands and one-hot control strobes and captures ALU_out/Fa_cout.
// Optional macro: DIV_ZERO_TRAP_EN (DIV by zero finishes at once with div_zero).
module alu_muldiv_seq #(
  parameter int ITER = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] opa,
  input  logic [3:0] opb,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       div_zero,
  output logic [3:0] AH_out,
  output logic [3:0] BREG_out,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       alu_and,
  output logic       alu_mul,
  output logic       alu_div,
  output logic       al_lsb,
  input  logic [3:0] ALU_out,
  input  logic       Fa_cout
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  // Count value seen on the last MSHIFT/DSUB pass.
  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MADD   = 3'd2,
    ST_MSHIFT = 3'd3,
    ST_DSHIFT = 3'd4,
    ST_DSUB   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  ah_r;
  logic [3:0]  al_r;
  logic [3:0]  b_r;
  logic [2:0]  cnt_r;
  logic        c_r;
  logic [2:0]  op_r;
  logic [7:0]  result_r;
  logic        accept_s;
  logic        trap_s;

  // Start is honoured only in IDLE and only for a defined opcode.
  assign accept_s = (state_r == ST_IDLE) && start && (op <= OP_DIV);

`ifdef DIV_ZERO_TRAP_EN
  logic div_zero_r;

  assign trap_s   = (op == OP_DIV) && (opb == 4'h0);
  assign div_zero = div_zero_r;

  // div_zero flags exactly the DONE cycle reached through the zero-divisor shortcut.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_zero_r <= 1'b0;
    end else begin
      div_zero_r <= (state_r == ST_IDLE) && (state_nxt_s == ST_DONE);
    end
  end
`else
  assign trap_s   = 1'b0;
  assign div_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_MUL:  state_nxt_s = ST_MADD;
            OP_DIV:  state_nxt_s = trap_s ? ST_DONE : ST_DSHIFT;
            default: state_nxt_s = ST_EXEC;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC:   state_nxt_s = ST_DONE;
      ST_MADD:   state_nxt_s = ST_MSHIFT;
      ST_MSHIFT: state_nxt_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_MADD;
      ST_DSHIFT: state_nxt_s = ST_DSUB;
      ST_DSUB:   state_nxt_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_DSHIFT;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake and ALU control decode; controls are one-hot only in EXEC/MADD/DSUB.
  always_comb begin
    busy    = (state_r != ST_IDLE);
    done    = (state_r == ST_DONE);
    alu_add = 1'b0;
    alu_sub = 1'b0;
    alu_and = 1'b0;
    alu_mul = 1'b0;
    alu_div = 1'b0;
    al_lsb  = 1'b0;
    case (state_r)
      ST_EXEC: begin
        alu_add = (op_r == OP_ADD);
        alu_sub = (op_r == OP_SUB);
        alu_and = (op_r == OP_AND);
      end
      ST_MADD: begin
        alu_mul = 1'b1;
        al_lsb  = al_r[0];
      end
      ST_DSUB: begin
        alu_div = 1'b1;
      end
      default: begin
        alu_add = 1'b0;
      end
    endcase
  end

  // Accumulator, operand latch, iteration counter and result capture.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ah_r     <= 4'h0;
      al_r     <= 4'h0;
      b_r      <= 4'h0;
      cnt_r    <= 3'd0;
      c_r      <= 1'b0;
      op_r     <= 3'b000;
      result_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            b_r   <= opb;
            cnt_r <= 3'd0;
            c_r   <= 1'b0;
            op_r  <= op;
            if ((op == OP_MUL) || (op == OP_DIV)) begin
              ah_r <= 4'h0;
              al_r <= opa;
            end else begin
              ah_r <= opa;
            end
            if (trap_s) begin
              // Same answer the full restoring sequence gives for a zero divisor.
              result_r <= {opa, 4'hF};
            end else begin
              result_r <= result_r;
            end
          end else begin
            ah_r <= ah_r;
          end
        end
        ST_EXEC: begin
          result_r <= {((op_r == OP_ADD) ? {3'b000, Fa_cout} : 4'h0), ALU_out};
        end
        ST_MADD: begin
          if (al_r[0]) begin
            ah_r <= ALU_out;
            c_r  <= Fa_cout;
          end else begin
            c_r  <= 1'b0;
          end
        end
        ST_MSHIFT: begin
          // 9-bit logical right shift of {C,AH,AL}.
          c_r   <= 1'b0;
          ah_r  <= {c_r, ah_r[3:1]};
          al_r  <= {ah_r[0], al_r[3:1]};
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == CNT_LAST) begin
            result_r <= {c_r, ah_r, al_r[3:1]};
          end else begin
            result_r <= result_r;
          end
        end
        ST_DSHIFT: begin
          ah_r <= {ah_r[2:0], al_r[3]};
          al_r <= {al_r[2:0], 1'b0};
        end
        ST_DSUB: begin
          // Fa_cout=1 means no borrow: keep the difference, else restore.
          cnt_r <= cnt_r + 3'd1;
          if (Fa_cout) begin
            ah_r    <= ALU_out;
            al_r[0] <= 1'b1;
          end else begin
            al_r[0] <= 1'b0;
          end
          if (cnt_r == CNT_LAST) begin
            result_r <= Fa_cout ? {ALU_out, al_r[3:1], 1'b1} : {ah_r, al_r[3:1], 1'b0};
          end else begin
            result_r <= result_r;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign result   = result_r;
  assign AH_out   = ah_r;
  assign BREG_out = b_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: self-checking bench for alu_muldiv_seq with a behavioural
// 4-bit ALU attached and an arithmetic reference model for results and latency.
module tb_alu_muldiv_seq;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       div_zero;
  logic [3:0] AH_out;
  logic [3:0] BREG_out;
  logic       alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb;
  logic [3:0] ALU_out;
  logic       Fa_cout;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Values collected by run_op.
  int         lat;
  logic [7:0] res;
  logic       dz;
  int         n_add, n_sub, n_and, n_mul, n_div;
  logic [3:0] lsb_seq;
  int         oh_err;
  int         busy_err;

  alu_muldiv_seq dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero),
    .AH_out(AH_out), .BREG_out(BREG_out),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and),
    .alu_mul(alu_mul), .alu_div(alu_div), .al_lsb(al_lsb),
    .ALU_out(ALU_out), .Fa_cout(Fa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: add for ADD/MUL, subtract (carry = no borrow) for SUB/DIV.
  always_comb begin
    ALU_out = 4'h0;
    Fa_cout = 1'b0;
    if (alu_add || alu_mul) begin
      {Fa_cout, ALU_out} = {1'b0, AH_out} + {1'b0, BREG_out};
    end else if (alu_sub || alu_div) begin
      ALU_out = AH_out - BREG_out;
      Fa_cout = (AH_out >= BREG_out);
    end else if (alu_and) begin
      ALU_out = AH_out & BREG_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    case (o)
      3'd0:    return 8'(a) + 8'(b);
      3'd1:    return {4'h0, 4'(a - b)};
      3'd2:    return {4'h0, a & b};
      3'd3:    return 8'(a) * 8'(b);
      3'd4:    return (b == 4'h0) ? {a, 4'hF} : {4'(a % b), 4'(a / b)};
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [3:0] b);
    if (o <= 3'd2) return 2;
`ifdef DIV_ZERO_TRAP_EN
    if ((o == 3'd4) && (b == 4'h0)) return 1;
`endif
    return 9;
  endfunction

  function automatic int ref_nctl(input logic [2:0] o, input logic [3:0] b);
    if (o <= 3'd2) return 1;
`ifdef DIV_ZERO_TRAP_EN
    if ((o == 3'd4) && (b == 4'h0)) return 0;
`endif
    return 4;
  endfunction

  function automatic logic [24:0] all_outs();
    return {busy, done, result, div_zero, AH_out, BREG_out,
            alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb};
  endfunction

  // Launch one operation and observe it cycle by cycle until done (bounded).
  // inj>0 reasserts start with an ADD during that cycle to prove it is ignored.
  task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input int inj);
    int k;
    int nctl;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = 4'($urandom); opb = 4'($urandom);
    lat = -1; res = 8'h00; dz = 1'b0; lsb_seq = 4'h0;
    n_add = 0; n_sub = 0; n_and = 0; n_mul = 0; n_div = 0; oh_err = 0; busy_err = 0;
    got = 1'b0;
    k = 1;
    while (!got && k <= 20) begin
      if (inj != 0 && k == inj) begin
        start = 1'b1; op = 3'b000; opa = 4'h1; opb = 4'h1;
      end
      if (!busy) busy_err++;
      nctl = int'(alu_add) + int'(alu_sub) + int'(alu_and) + int'(alu_mul) + int'(alu_div);
      if (nctl > 1 || (al_lsb && !alu_mul) || (done && nctl != 0)) oh_err++;
      n_add += int'(alu_add); n_sub += int'(alu_sub); n_and += int'(alu_and);
      n_mul += int'(alu_mul); n_div += int'(alu_div);
      if (alu_mul) lsb_seq = {lsb_seq[2:0], al_lsb};
      if (done) begin
        got = 1'b1; lat = k; res = result; dz = div_zero;
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        k++;
      end
    end
    @(posedge clk); #1;
    check("done_drop", {30'd0, done, busy}, 32'd0);
    check("result_hold", 32'(result), 32'(res));
  endtask

  task automatic check_op(input string tag, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    check({tag, "_result"}, 32'(res), 32'(ref_res(o, a, b)));
    check({tag, "_latency"}, lat, ref_lat(o, b));
    check({tag, "_nctl"}, n_add + n_sub + n_and + n_mul + n_div, ref_nctl(o, b));
    check({tag, "_onehot"}, oh_err, 0);
    check({tag, "_busy"}, busy_err, 0);
  endtask

  initial begin
    int ndone;
    logic [2:0] ro;
    logic [3:0] ra, rb;

    clr_n = 1'b0; start = 1'b0; op = 3'b000; opa = 4'h0; opb = 4'h0;
    #12;
    check("reset_outs", 32'(all_outs()), 32'd0);
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", 32'(all_outs()), 32'd0);

    // MUL 13 x 11
    run_op(3'd3, 4'd13, 4'd11, 0);
    check_op("mul13x11", 3'd3, 4'd13, 4'd11);
    check("mul_result_const", 32'(res), 32'h8F);
    check("mul_pulses", n_mul, 4);
    check("mul_lsb_seq", 32'(lsb_seq), 32'hB);

    // DIV 13 / 3
    run_op(3'd4, 4'd13, 4'd3, 0);
    check_op("div13by3", 3'd4, 4'd13, 4'd3);
    check("div_result_const", 32'(res), 32'h14);
    check("div_pulses", n_div, 4);
    check("div_dz", 32'(dz), 32'd0);

    // ADD 9 + 8, SUB 3 - 5
    run_op(3'd0, 4'd9, 4'd8, 0);
    check_op("add9p8", 3'd0, 4'd9, 4'd8);
    check("add_result_const", 32'(res), 32'h11);
    check("add_pulses", n_add, 1);
    run_op(3'd1, 4'd3, 4'd5, 0);
    check_op("sub3m5", 3'd1, 4'd3, 4'd5);
    check("sub_result_const", 32'(res), 32'h0E);
    check("sub_pulses", n_sub, 1);

    // Divide by zero
    run_op(3'd4, 4'd7, 4'd0, 0);
    check_op("div7by0", 3'd4, 4'd7, 4'd0);
    check("div0_result_const", 32'(res), 32'h7F);
`ifdef DIV_ZERO_TRAP_EN
    check("div0_flag", 32'(dz), 32'd1);
    check("div0_lat_const", lat, 1);
`else
    check("div0_flag", 32'(dz), 32'd0);
    check("div0_lat_const", lat, 9);
`endif

    // Invalid opcodes are ignored
    for (int i = 5; i < 8; i++) begin
      @(negedge clk); start = 1'b1; op = 3'(i); opa = 4'hA; opb = 4'h5;
      @(posedge clk); #1; start = 1'b0;
      check("invalid_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("invalid_done", {30'd0, busy, done}, 32'd0);
    end

    // Start while busy is ignored
    run_op(3'd3, 4'd15, 4'd15, 4);
    check_op("mul_busy_start", 3'd3, 4'd15, 4'd15);
    check("busy_start_result", 32'(res), 32'hE1);

    // Reset mid-operation
    @(negedge clk); start = 1'b1; op = 3'd3; opa = 4'hF; opb = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    check("midreset_outs", 32'(all_outs()), 32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midreset_nodone", ndone, 0);
    @(negedge clk); clr_n = 1'b1;
    run_op(3'd0, 4'd1, 4'd1, 0);
    check_op("add1p1", 3'd0, 4'd1, 4'd1);
    check("after_reset_result", 32'(res), 32'h02);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(4, 0));
      ra = 4'($urandom);
      rb = (i % 10 == 0) ? 4'h0 : 4'($urandom);
      run_op(ro, ra, rb, 0);
      check_op("rand", ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
